serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
- Parametrised parallel-in/serial-out transmitter.
- Successor to the fixed 8-bit PISO encoder. Replaces its free-running load counter with a valid/ready handshake, adds start/stop framing, a configurable bit period and configurable bit order.
- Sits between the encrypter output and the transmitted_data line in the Messenger transmission path.
- Reports frame completion and keeps a running frame count.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 1..64.
- CLKS_PER_BIT, 1, clock cycles each line bit is held; legal range 1..65535.
- LSB_FIRST, 1, 1 = payload bit 0 sent first; 0 = bit DATA_WIDTH-1 sent first.
- IDLE_LEVEL, 1, line level while idle and for the stop bit; the start bit is ~IDLE_LEVEL.

Ports:
- clock, input, 1, single clock; all state changes on the rising edge.
- reset_n, input, 1, synchronous, active-low reset.
- parallelIn, input, DATA_WIDTH, payload word; sampled only at acceptance.
- inValid, input, 1, source has a word on parallelIn.
- inReady, output, 1, block can accept a word this cycle.
- serialOut, output, 1, registered serial line.
- busy, output, 1, high while a frame is on the line (START through STOP).
- frameDone, output, 1, one-cycle pulse after the final stop-bit cycle.
- frameCount, output, 16, completed frames since reset.

Behaviour:
- Reset: when reset_n=0 at a rising edge:
  - state=IDLE, serialOut=IDLE_LEVEL, busy=0, frameDone=0, frameCount=0, shift register=0, bit-period and bit-index counters=0.
  - inReady is forced to 0 while reset_n=0.
- Reset mid-frame aborts the frame: the line returns to IDLE_LEVEL at that edge, no frameDone, frameCount unchanged.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
- inReady (combinational from state) is 1 in two cases:
  - in IDLE;
  - in the last cycle of STOP (bit-period counter = CLKS_PER_BIT-1).
- Acceptance = inValid && inReady at a rising edge:
  - parallelIn is latched into the shift register;
  - the next state is START;
  - serialOut = ~IDLE_LEVEL starting the cycle after acceptance (latency 1).
- Changes on parallelIn after acceptance have no effect on the frame.
- inValid while inReady=0 is not accepted and not dropped; the source holds it.
- Bit period: each line bit is held exactly CLKS_PER_BIT cycles. The bit-period counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on advancing to the next bit.
- DATA state:
  - sends DATA_WIDTH bits;
  - the bit index counts 0..DATA_WIDTH-1;
  - shift direction is set by LSB_FIRST.
- STOP state drives serialOut=IDLE_LEVEL for one bit period.
- Frame length = (DATA_WIDTH+2)*CLKS_PER_BIT cycles, or (DATA_WIDTH+3)*CLKS_PER_BIT with parity.
- Back-to-back: acceptance in the last STOP cycle sends the next start bit immediately, with no idle gap.
- frameDone is high for exactly one cycle: the cycle after the last STOP cycle, which is also the first cycle of the next START if streaming.
- frameCount increments with each frameDone and wraps 16'hFFFF -> 0.
- busy = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- IDLE without acceptance: serialOut holds IDLE_LEVEL.
- With DATA_WIDTH=1, DATA lasts one bit period.
- With CLKS_PER_BIT=1, every state advances every cycle.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - a PARITY state between DATA and STOP drives one bit period of even parity (XOR of all latched payload bits);
  - frame length grows by one bit.
- Undefined:
  - no PARITY state; DATA goes directly to STOP;
  - no parity logic is synthesised.

Test Plan:
- Basic frame: DATA_WIDTH=8, CLKS_PER_BIT=1, LSB_FIRST=1, IDLE_LEVEL=1; send 8'h41 with one-cycle inValid.
  -> serialOut 0,1,0,0,0,0,0,1,0,1 on the cycles after acceptance;
  -> frameDone on cycle 11 after acceptance; frameCount=1; busy high for 10 cycles.
- Bit order: LSB_FIRST=0, send 8'h41.
  -> 0,0,1,0,0,0,0,0,1,1.
- Parity: SERIAL_FRAME_TX_PARITY_EN defined.
  -> 8'h41 gives 0,1,0,0,0,0,0,1,0,0,1 (parity 0);
  -> 8'h43 gives parity bit 1; frame is 11 cycles.
- Streaming with bit period: CLKS_PER_BIT=4; inValid held high with 8'hA5 then 8'h3C.
  -> each bit held 4 cycles;
  -> second start bit immediately follows the first stop bit;
  -> 80 busy cycles; frameCount=2; two frameDone pulses 40 cycles apart.
- Reset mid-frame: reset_n=0 for one edge during data bit 3.
  -> serialOut=1 and busy=0 from that edge;
  -> no frameDone; frameCount=0;
  -> inReady=1 in the first cycle after reset_n returns high;
  -> a following frame is transmitted cleanly.
- Backpressure: inValid asserted while busy with a new word held stable.
  -> not accepted until the last STOP cycle;
  -> transmitted word equals the held value;
  -> a word changed on parallelIn after acceptance does not alter the frame.

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: handshake and line bundle for the serial frame transmitter.
// The master side is the word source; the slave side is the transmitter itself.
interface serial_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] parallelIn;
  logic                  inValid;
  logic                  inReady;
  logic                  serialOut;
  logic                  busy;
  logic                  frameDone;
  logic [15:0]           frameCount;

  modport master (
    output parallelIn,
    output inValid,
    input  inReady,
    input  serialOut,
    input  busy,
    input  frameDone,
    input  frameCount
  );

  modport slave (
    input  parallelIn,
    input  inValid,
    output inReady,
    output serialOut,
    output busy,
    output frameDone,
    output frameCount
  );

endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in/serial-out frame transmitter with valid/ready intake,
// start/stop framing, configurable bit period and bit order.
// Optional even-parity bit between data and stop: define SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit LSB_FIRST    = 1'b1,
  parameter bit IDLE_LEVEL   = 1'b1
) (
  input logic i_clock,
  input logic i_reset_n,
  serial_frame_tx_if.slave bus
);

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [6:0]  LAST_BIT  = 7'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_nextShift;
  logic [15:0]           r_tick;
  logic [15:0]           w_nextTick;
  logic [6:0]            r_bitIdx;
  logic [6:0]            w_nextBitIdx;
  logic                  r_serialOut;
  logic                  w_nextSerialOut;
  logic                  r_frameDone;
  logic                  w_frameEnd;
  logic [15:0]           r_frameCount;
  logic                  w_lastTick;
  logic                  w_accept;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic                  r_parity;
  logic                  w_nextParity;
`endif

  // Bit that goes on the line next, taken from the end chosen by LSB_FIRST.
  function automatic logic headBit(input logic [DATA_WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
  endfunction

  // Drops the bit just sent so the following one moves to the head position.
  function automatic logic [DATA_WIDTH-1:0] shiftOut(input logic [DATA_WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  assign w_lastTick     = (r_tick == LAST_TICK);
  assign bus.inReady    = i_reset_n && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_lastTick));
  assign w_accept       = bus.inValid && bus.inReady;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.serialOut  = r_serialOut;
  assign bus.frameDone  = r_frameDone;
  assign bus.frameCount = r_frameCount;

  // Holds the frame state; reset aborts any frame in flight.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Decides the next state and what the line carries next; serialOut is registered,
  // so the value computed here is the bit of the state being entered.
  always_comb begin
    w_nextState     = r_state;
    w_nextShift     = r_shift;
    w_nextTick      = w_lastTick ? 16'd0 : (r_tick + 16'd1);
    w_nextBitIdx    = r_bitIdx;
    w_nextSerialOut = r_serialOut;
    w_frameEnd      = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    w_nextParity    = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        w_nextTick      = 16'd0;
        w_nextSerialOut = IDLE_LEVEL;
      end
      ST_START: begin
        if (w_lastTick) begin
          w_nextState     = ST_DATA;
          w_nextBitIdx    = 7'd0;
          w_nextSerialOut = headBit(r_shift);
        end
      end
      ST_DATA: begin
        if (w_lastTick) begin
          if (r_bitIdx == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            w_nextState     = ST_PARITY;
            w_nextSerialOut = r_parity;
`else
            w_nextState     = ST_STOP;
            w_nextSerialOut = IDLE_LEVEL;
`endif
          end else begin
            w_nextBitIdx    = r_bitIdx + 7'd1;
            w_nextShift     = shiftOut(r_shift);
            w_nextSerialOut = headBit(shiftOut(r_shift));
          end
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      ST_PARITY: begin
        if (w_lastTick) begin
          w_nextState     = ST_STOP;
          w_nextSerialOut = IDLE_LEVEL;
        end
      end
`endif
      ST_STOP: begin
        if (w_lastTick) begin
          w_frameEnd      = 1'b1;
          w_nextState     = ST_IDLE;
          w_nextSerialOut = IDLE_LEVEL;
        end
      end
      default: begin
        w_nextState     = ST_IDLE;
        w_nextSerialOut = IDLE_LEVEL;
      end
    endcase
    // Acceptance only happens in IDLE or the last STOP cycle, so it simply
    // overrides whatever those states chose and starts a fresh frame.
    if (w_accept) begin
      w_nextState     = ST_START;
      w_nextShift     = bus.parallelIn;
      w_nextTick      = 16'd0;
      w_nextSerialOut = ~IDLE_LEVEL;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      w_nextParity    = ^bus.parallelIn;
`endif
    end
  end

  // Updates the datapath registers and the completion pulse/counter.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_shift      <= '0;
      r_tick       <= 16'd0;
      r_bitIdx     <= 7'd0;
      r_serialOut  <= IDLE_LEVEL;
      r_frameDone  <= 1'b0;
      r_frameCount <= 16'd0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_shift     <= w_nextShift;
      r_tick      <= w_nextTick;
      r_bitIdx    <= w_nextBitIdx;
      r_serialOut <= w_nextSerialOut;
      r_frameDone <= w_frameEnd;
      if (w_frameEnd) begin
        r_frameCount <= r_frameCount + 16'd1;
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_parity    <= w_nextParity;
`endif
    end
  end

endmodule
